lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_align.sv | 61 ++++++
 rtl/lsu.sv | 172 +++++++++++++++++
 tb/tb_lsu.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Desc   : Shared size encodings, FSM states and helpers for the load/store unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_WB   = 2'b11
  } lsu_state_t;

  // Any encoding other than byte/half is handled as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module : lsu_align
// Desc   : Combinational lane extraction, sign-extension, store replication and
//          byte-strobe generation for the load/store unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_ld_raw,
  output logic [31:0] o_st_wdata,
  output logic [3:0]  o_st_wstrb,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_ld_raw[7:0];
    case (i_addr_lo)
      2'b00:   w_byte = i_ld_raw[7:0];
      2'b01:   w_byte = i_ld_raw[15:8];
      2'b10:   w_byte = i_ld_raw[23:16];
      default: w_byte = i_ld_raw[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_ld_raw[31:16] : i_ld_raw[15:0];
  end

  always_comb begin
    o_ld_data  = i_ld_raw;
    o_st_wdata = i_st_data;
    o_st_wstrb = 4'b1111;
    case (i_size)
      SZ_B: begin
        o_ld_data  = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
        o_st_wdata = {4{i_st_data[7:0]}};
        o_st_wstrb = 4'b0001 << i_addr_lo;
      end
      SZ_H: begin
        o_ld_data  = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
        o_st_wdata = {2{i_st_data[15:0]}};
        o_st_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
      end
      default: begin
        o_ld_data  = i_ld_raw;
        o_st_wdata = i_st_data;
        o_st_wstrb = 4'b1111;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
// Module : lsu
// Desc   : Single-outstanding load/store unit with req/gnt/rvalid memory port.
//          Optional macro LSU_MISALIGN_CHECK_EN rejects misaligned half/word.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu
  import lsu_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        gpr_wen,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  output logic        done,
  output logic        err_misalign
);

  lsu_state_t  r_state;
  logic        r_we;
  logic [1:0]  r_addr_lo;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [4:0]  r_rd;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic        r_gpr_wen;
  logic [4:0]  r_gpr_waddr;
  logic [31:0] r_gpr_wdata;
  logic        r_done;
  logic        r_err;

  logic        w_idle;
  logic        w_misalign;
  logic [1:0]  w_sel_size;
  logic [1:0]  w_sel_addr_lo;
  logic        w_sel_unsigned;
  logic [31:0] w_st_wdata;
  logic [3:0]  w_st_wstrb;
  logic [31:0] w_ld_data;

  assign w_idle = (r_state == ST_IDLE);

  // Store formatting happens at accept from the live request; load extraction
  // happens later from the captured fields.
  assign w_sel_size     = w_idle ? req_size       : r_size;
  assign w_sel_addr_lo  = w_idle ? req_addr[1:0]  : r_addr_lo;
  assign w_sel_unsigned = w_idle ? req_unsigned   : r_unsigned;

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign = is_misaligned(req_size, req_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  lsu_align u_align (
    .i_size     (w_sel_size),
    .i_addr_lo  (w_sel_addr_lo),
    .i_unsigned (w_sel_unsigned),
    .i_st_data  (req_wdata),
    .i_ld_raw   (mem_rdata),
    .o_st_wdata (w_st_wdata),
    .o_st_wstrb (w_st_wstrb),
    .o_ld_data  (w_ld_data)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_addr_lo   <= 2'b00;
      r_size      <= SZ_B;
      r_unsigned  <= 1'b0;
      r_rd        <= 5'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wstrb <= 4'd0;
      r_gpr_wen   <= 1'b0;
      r_gpr_waddr <= 5'd0;
      r_gpr_wdata <= 32'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_gpr_wen <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_addr_lo  <= req_addr[1:0];
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_rd       <= req_rd;
            if (w_misalign) begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= req_we;
              r_mem_addr  <= {req_addr[31:2], 2'b00};
              r_mem_wdata <= w_st_wdata;
              r_mem_wstrb <= req_we ? w_st_wstrb : 4'b0000;
              r_state     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            if (r_we) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_gpr_wen   <= (r_rd != 5'd0);
            r_gpr_waddr <= r_rd;
            r_gpr_wdata <= w_ld_data;
            r_done      <= 1'b1;
            r_state     <= ST_WB;
          end
        end
        ST_WB:   r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = w_idle;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_wstrb    = r_mem_wstrb;
  assign gpr_wen      = r_gpr_wen;
  assign gpr_waddr    = r_gpr_waddr;
  assign gpr_wdata    = r_gpr_wdata;
  assign done         = r_done;
  assign err_misalign = r_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
// Module : tb_lsu
// Desc   : Self-checking bench for lsu: vector table plus multi-cycle sequences.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu;

  logic        sys_clk, sys_rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic [4:0]  req_rd;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        gpr_wen, done, err_misalign;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;

  lsu dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_rd(req_rd),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .done(done), .err_misalign(err_misalign)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_gpr;
    logic        exp_wen;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  int n_vec = 0;
  int n_bad = 0;
  int wen_cnt = 0;
  int mreq_cnt = 0;
  int err_cnt = 0;

  always @(posedge sys_clk) begin
    if (gpr_wen)      wen_cnt++;
    if (mem_req)      mreq_cnt++;
    if (err_misalign) err_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_rd       = v.rd;
  endtask

  // Full transaction; rvalid always comes at the first opportunity so the
  // fixed schedule below also pins the latency.
  task automatic do_txn(input vec_t v, input int gnt_wait, input string tag);
    @(negedge sys_clk);
    chk({tag, ".ready_idle"}, {31'd0, req_ready}, 32'd1);
    drive_req(v);
    @(posedge sys_clk); #1 req_valid = 1'b0;
    for (int k = 0; k <= gnt_wait; k++) begin
      @(negedge sys_clk);
      chk({tag, ".mem_req"},  {31'd0, mem_req}, 32'd1);
      chk({tag, ".mem_we"},   {31'd0, mem_we}, {31'd0, v.we});
      chk({tag, ".mem_addr"}, mem_addr, v.exp_addr);
      if (v.we) begin
        chk({tag, ".mem_wdata"}, mem_wdata, v.exp_wdata);
        chk({tag, ".mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, v.exp_wstrb});
      end
      chk({tag, ".ready_busy"}, {31'd0, req_ready}, 32'd0);
      chk({tag, ".early_done"}, {31'd0, done | gpr_wen}, 32'd0);
      if (k == gnt_wait) mem_gnt = 1'b1;
    end
    @(posedge sys_clk); #1 mem_gnt = 1'b0;
    @(negedge sys_clk);
    chk({tag, ".req_drop"}, {31'd0, mem_req}, 32'd0);
    if (v.we) begin
      chk({tag, ".st_done"}, {31'd0, done}, 32'd1);
      chk({tag, ".st_wen"},  {31'd0, gpr_wen}, 32'd0);
    end else begin
      chk({tag, ".wait_quiet"}, {31'd0, done | gpr_wen | req_ready}, 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = v.rdata;
      @(posedge sys_clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hA5A5_5A5A;
      @(negedge sys_clk);
      chk({tag, ".gpr_wen"}, {31'd0, gpr_wen}, {31'd0, v.exp_wen});
      chk({tag, ".ld_done"}, {31'd0, done}, 32'd1);
      if (v.exp_wen) begin
        chk({tag, ".gpr_waddr"}, {27'd0, gpr_waddr}, {27'd0, v.rd});
        chk({tag, ".gpr_wdata"}, gpr_wdata, v.exp_gpr);
      end
    end
    @(negedge sys_clk);
    chk({tag, ".pulse_end"}, {31'd0, done | gpr_wen}, 32'd0);
    chk({tag, ".ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w0;
    int m0;
    vec_t h;
    //            we    addr          wdata         sz     uns   rd     rdata         exp_addr      exp_wdata     strb     exp_gpr       wen
    vecs[0]  = '{1'b0, 32'h8000_0004, 32'h0,        2'b10, 1'b0, 5'd5,  32'hDEAD_BEEF, 32'h8000_0004, 32'h0,        4'h0, 32'hDEAD_BEEF, 1'b1};
    vecs[1]  = '{1'b0, 32'h8000_0003, 32'h0,        2'b00, 1'b0, 5'd7,  32'h8011_2233, 32'h8000_0000, 32'h0,        4'h0, 32'hFFFF_FF80, 1'b1};
    vecs[2]  = '{1'b0, 32'h8000_0003, 32'h0,        2'b00, 1'b1, 5'd7,  32'h8011_2233, 32'h8000_0000, 32'h0,        4'h0, 32'h0000_0080, 1'b1};
    vecs[3]  = '{1'b0, 32'h8000_0002, 32'h0,        2'b01, 1'b0, 5'd9,  32'h8011_2233, 32'h8000_0000, 32'h0,        4'h0, 32'hFFFF_8011, 1'b1};
    vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,        2'b01, 1'b1, 5'd10, 32'h1234_F00D, 32'h0000_0010, 32'h0,        4'h0, 32'h0000_F00D, 1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0011, 32'h0,        2'b00, 1'b0, 5'd31, 32'h1234_F00D, 32'h0000_0010, 32'h0,        4'h0, 32'hFFFF_FFF0, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0020, 32'h0,        2'b11, 1'b1, 5'd1,  32'h8000_0001, 32'h0000_0020, 32'h0,        4'h0, 32'h8000_0001, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0014, 32'h0,        2'b01, 1'b0, 5'd2,  32'h0000_7FFF, 32'h0000_0014, 32'h0,        4'h0, 32'h0000_7FFF, 1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0024, 32'h0,        2'b10, 1'b0, 5'd0,  32'h0000_0055, 32'h0000_0024, 32'h0,        4'h0, 32'h0000_0055, 1'b0};
    vecs[9]  = '{1'b1, 32'h4000_0001, 32'h1234_56A5, 2'b00, 1'b0, 5'd3,  32'h0,        32'h4000_0000, 32'hA5A5_A5A5, 4'h2, 32'h0,        1'b0};
    vecs[10] = '{1'b1, 32'h0000_0008, 32'hCAFE_F00D, 2'b10, 1'b0, 5'd3,  32'h0,        32'h0000_0008, 32'hCAFE_F00D, 4'hF, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 32'h0000_000C, 32'h0102_0304, 2'b11, 1'b1, 5'd3,  32'h0,        32'h0000_000C, 32'h0102_0304, 4'hF, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 32'h0000_0004, 32'hFFFF_1357, 2'b01, 1'b0, 5'd3,  32'h0,        32'h0000_0004, 32'h1357_1357, 4'h3, 32'h0,        1'b0};
    vecs[13] = '{1'b1, 32'h0000_0007, 32'h0000_003C, 2'b00, 1'b0, 5'd3,  32'h0,        32'h0000_0004, 32'h3C3C_3C3C, 4'h8, 32'h0,        1'b0};

    sys_rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_size = 2'b00; req_unsigned = 1'b0; req_rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hA5A5_5A5A;

    #2;
    chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst.outs", {31'd0, gpr_wen | done | err_misalign}, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.gpr_wdata", gpr_wdata, 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst.ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      w0 = wen_cnt;
      do_txn(vecs[i], 0, $sformatf("v%0d", i));
      chk($sformatf("v%0d.wen_count", i), wen_cnt - w0, vecs[i].exp_wen ? 32'd1 : 32'd0);
    end

    // Half store held off by three cycles of no grant.
    h = '{1'b1, 32'h8000_0002, 32'h0000_ABCD, 2'b01, 1'b0, 5'd4, 32'h0,
          32'h8000_0000, 32'hABCD_ABCD, 4'hC, 32'h0, 1'b0};
    w0 = wen_cnt;
    do_txn(h, 3, "st_gnt_wait");
    chk("st_gnt_wait.no_wen", wen_cnt - w0, 32'd0);

    // rvalid while idle and in the grant cycle must be ignored.
    w0 = wen_cnt;
    @(negedge sys_clk); mem_rvalid = 1'b1;
    @(posedge sys_clk); #1 mem_rvalid = 1'b0;
    @(negedge sys_clk);
    chk("idle_rvalid.wen", wen_cnt - w0, 32'd0);
    h = '{1'b0, 32'h0000_0030, 32'h0, 2'b10, 1'b0, 5'd3, 32'h2222_2222,
          32'h0000_0030, 32'h0, 4'h0, 32'h2222_2222, 1'b1};
    drive_req(h);
    @(posedge sys_clk); #1 req_valid = 1'b0;
    @(negedge sys_clk); mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    @(posedge sys_clk); #1 mem_gnt = 1'b0; mem_rvalid = 1'b0;
    repeat (2) begin
      @(negedge sys_clk);
      chk("gnt_rvalid.wait", {31'd0, gpr_wen | done | req_ready}, 32'd0);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
    @(posedge sys_clk); #1 mem_rvalid = 1'b0;
    @(negedge sys_clk);
    chk("gnt_rvalid.wen", {31'd0, gpr_wen}, 32'd1);
    chk("gnt_rvalid.wdata", gpr_wdata, 32'h2222_2222);
    chk("gnt_rvalid.waddr", {27'd0, gpr_waddr}, 32'd3);

    // Asynchronous reset while waiting for read data.
    @(negedge sys_clk);
    h = '{1'b0, 32'h0000_0034, 32'h0, 2'b10, 1'b0, 5'd4, 32'h0,
          32'h0000_0034, 32'h0, 4'h0, 32'h0, 1'b0};
    drive_req(h);
    @(posedge sys_clk); #1 req_valid = 1'b0;
    @(negedge sys_clk); mem_gnt = 1'b1;
    @(posedge sys_clk); #1 mem_gnt = 1'b0;
    @(negedge sys_clk);
    chk("rst_wait.in_wait", {31'd0, req_ready}, 32'd0);
    sys_rst = 1'b1;
    #1;
    chk("rst_wait.ready", {31'd0, req_ready}, 32'd1);
    chk("rst_wait.mem_addr", mem_addr, 32'd0);
    chk("rst_wait.gpr_wdata", gpr_wdata, 32'd0);
    @(negedge sys_clk); sys_rst = 1'b0;
    w0 = wen_cnt;
    @(negedge sys_clk); mem_rvalid = 1'b1; mem_rdata = 32'h3333_3333;
    @(posedge sys_clk); #1 mem_rvalid = 1'b0;
    @(negedge sys_clk);
    chk("rst_wait.late_rvalid", wen_cnt - w0, 32'd0);
    chk("rst_wait.idle", {31'd0, req_ready}, 32'd1);
    chk("rst_wait.no_done", {31'd0, done}, 32'd0);

    // Misaligned word load.
    h = '{1'b0, 32'h8000_0001, 32'h0, 2'b10, 1'b0, 5'd6, 32'h1122_3344,
          32'h8000_0000, 32'h0, 4'h0, 32'h1122_3344, 1'b1};
`ifdef LSU_MISALIGN_CHECK_EN
    m0 = mreq_cnt;
    w0 = wen_cnt;
    @(negedge sys_clk);
    drive_req(h);
    @(posedge sys_clk); #1 req_valid = 1'b0;
    @(negedge sys_clk);
    chk("mis.err", {31'd0, err_misalign}, 32'd1);
    chk("mis.done", {31'd0, done}, 32'd1);
    chk("mis.ready", {31'd0, req_ready}, 32'd1);
    @(negedge sys_clk);
    chk("mis.pulse_end", {31'd0, err_misalign | done}, 32'd0);
    chk("mis.no_mem_req", mreq_cnt - m0, 32'd0);
    chk("mis.no_wen", wen_cnt - w0, 32'd0);
`else
    m0 = err_cnt;
    do_txn(h, 0, "mis");
    chk("mis.no_err", err_cnt - m0, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
